// File: rtl/div_exec_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One op at a time; the result is held on a CDB request until the arbiter grants it.
module div_exec_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_issue_valid,
  input  logic [DATA_W-1:0] i_rs1_data,
  input  logic [DATA_W-1:0] i_rs2_data,
  input  logic [2:0]        i_funct3,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic              i_flush,
  input  logic              i_cdb_grant,
  output logic              o_busy,
  output logic              o_cdb_req,
  output logic [TAG_W-1:0]  o_cdb_tag,
  output logic [DATA_W-1:0] o_cdb_result
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e              state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                is_rem_q, is_rem_d;
  logic                quo_neg_q, quo_neg_d;
  logic                rem_neg_q, rem_neg_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvsr_q, dvsr_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [5:0]          cnt_q, cnt_d;

  // Operand decode at acceptance
  logic              op_signed, op_rem, a_neg, b_neg, div_zero, sgn_ovf;
  logic [DATA_W-1:0] abs_a, abs_b, q_fix, r_fix;
  logic [DATA_W:0]   rem_sh, trial;
  logic              fits;

  always_comb begin
    op_signed = (i_funct3 == 3'd4) || (i_funct3 == 3'd6);
    op_rem    = (i_funct3 == 3'd6) || (i_funct3 == 3'd7);
    a_neg     = op_signed && i_rs1_data[DATA_W-1];
    b_neg     = op_signed && i_rs2_data[DATA_W-1];
    abs_a     = a_neg ? ('0 - i_rs1_data) : i_rs1_data;
    abs_b     = b_neg ? ('0 - i_rs2_data) : i_rs2_data;
    div_zero  = (i_rs2_data == '0);
    sgn_ovf   = op_signed && (i_rs1_data == {1'b1, {(DATA_W-1){1'b0}}}) && (i_rs2_data == '1);
    // The bit shifted out of rem is the 33rd bit of the partial remainder; when set,
    // the trial subtraction always fits even though the 33-bit difference looks negative.
    rem_sh    = {rem_q, quo_q[DATA_W-1]};
    trial     = rem_sh - {1'b0, dvsr_q};
    fits      = rem_q[DATA_W-1] | ~trial[DATA_W];
    q_fix     = quo_neg_q ? ('0 - quo_q) : quo_q;
    r_fix     = rem_neg_q ? ('0 - rem_q) : rem_q;
  end

  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    is_rem_d  = is_rem_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    if (i_flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_issue_valid) begin
            tag_d     = i_tag;
            is_rem_d  = op_rem;
            quo_neg_d = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            quo_d     = abs_a;
            dvsr_d    = abs_b;
            rem_d     = '0;
            cnt_d     = '0;
            if (div_zero) begin
              result_d = op_rem ? i_rs1_data : '1;
              state_d  = StDone;
            end else if (sgn_ovf) begin
              result_d = op_rem ? '0 : i_rs1_data;
              state_d  = StDone;
            end else begin
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          rem_d = fits ? trial[DATA_W-1:0] : rem_sh[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], fits};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = StFix;
        end
        StFix: begin
          result_d = is_rem_q ? r_fix : q_fix;
          state_d  = StDone;
        end
        StDone: begin
          if (i_cdb_grant) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      tag_q     <= '0;
      is_rem_q  <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      is_rem_q  <= is_rem_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_busy       = (state_q != StIdle);
  assign o_cdb_req    = (state_q == StDone);
  assign o_cdb_tag    = tag_q;
  assign o_cdb_result = result_q;

endmodule

// File: tb/tb_div_exec_unit.sv
// Randomised and directed bench for div_exec_unit: expected CDB broadcasts are queued at
// issue time and a negedge monitor pops and compares each granted broadcast.
module tb_div_exec_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_issue_valid, i_flush, i_cdb_grant;
  logic [31:0] i_rs1_data, i_rs2_data;
  logic [2:0]  i_funct3;
  logic [5:0]  i_tag;
  logic        o_busy, o_cdb_req;
  logic [5:0]  o_cdb_tag;
  logic [31:0] o_cdb_result;

  div_exec_unit #(.DATA_W(32), .TAG_W(6)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_issue_valid(i_issue_valid),
    .i_rs1_data   (i_rs1_data),
    .i_rs2_data   (i_rs2_data),
    .i_funct3     (i_funct3),
    .i_tag        (i_tag),
    .i_flush      (i_flush),
    .i_cdb_grant  (i_cdb_grant),
    .o_busy       (o_busy),
    .o_cdb_req    (o_cdb_req),
    .o_cdb_tag    (o_cdb_tag),
    .o_cdb_result (o_cdb_result)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] res;
    int          lat;
    int          icyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model straight from the RV32M definition
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    int signed sa, sb;
    logic sgn, ovf;
    sa  = a;
    sb  = b;
    sgn = (f3 == 3'd4) || (f3 == 3'd6);
    ovf = sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd6:    return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      3'd7:    return (b == 0) ? a : a % b;
      default: return (b == 0) ? 32'hFFFF_FFFF : a / b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    logic sgn;
    sgn = (f3 == 3'd4) || (f3 == 3'd6);
    if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  // Monitor: latency measured from issue cycle to first cycle with o_cdb_req high
  initial begin
    logic prev_req;
    int   rise_cyc;
    exp_t e;
    prev_req = 1'b0;
    rise_cyc = 0;
    forever begin
      @(negedge i_clk);
      if (o_cdb_req && !prev_req) rise_cyc = cyc;
      prev_req = o_cdb_req;
      if (i_rst_n && o_cdb_req && i_cdb_grant && !i_flush) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_broadcast", 32'(o_cdb_tag), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("cdb_tag", 32'(o_cdb_tag), 32'(e.tag));
          chk("cdb_result", o_cdb_result, e.res);
          chk("latency", 32'(rise_cyc - e.icyc), 32'(e.lat));
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag, input bit expect_it);
    exp_t e;
    int   n;
    n = 0;
    while (o_busy && n < 100) begin
      tick();
      n++;
    end
    if (o_busy) chk("idle_timeout", 32'(o_busy), 32'd0);
    i_issue_valid = 1'b1;
    i_funct3      = f3;
    i_rs1_data    = a;
    i_rs2_data    = b;
    i_tag         = tag;
    if (expect_it) begin
      e.tag  = tag;
      e.res  = ref_result(f3, a, b);
      e.lat  = ref_lat(f3, a, b);
      e.icyc = cyc;
      exp_q.push_back(e);
    end
    tick();
    i_issue_valid = 1'b0;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!o_cdb_req && n < 60) begin
      tick();
      n++;
    end
    if (!o_cdb_req) chk("req_timeout", 32'(o_cdb_req), 32'd1);
  endtask

  // Full op with grant held high; busy must be low the cycle after the grant edge
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] tag);
    issue(f3, a, b, tag, 1'b1);
    wait_req();
    tick();
    chk("busy_after_grant", 32'(o_busy), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b, exp_r;
    logic [2:0]  f3;
    i_rst_n       = 1'b0;
    i_issue_valid = 1'b0;
    i_flush       = 1'b0;
    i_cdb_grant   = 1'b1;
    i_rs1_data    = '0;
    i_rs2_data    = '0;
    i_funct3      = '0;
    i_tag         = '0;
    tick();
    tick();
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_req", 32'(o_cdb_req), 32'd0);
    chk("rst_tag", 32'(o_cdb_tag), 32'd0);
    chk("rst_result", o_cdb_result, 32'd0);
    i_rst_n = 1'b1;
    tick();

    run_op(3'd5, 32'd100, 32'd7, 6'd5);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 6'd6);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 6'd7);
    run_op(3'd7, 32'hFFFF_FFF9, 32'd2, 6'd8);
    run_op(3'd4, 32'd5, 32'd0, 6'd9);
    run_op(3'd6, 32'd5, 32'd0, 6'd10);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 6'd11);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 6'd12);
    run_op(3'd5, 32'hFFFF_FFFF, 32'h8000_0001, 6'd13);

    // Grant withheld: held result stable, stray issue ignored
    i_cdb_grant = 1'b0;
    issue(3'd5, 32'd1000, 32'd3, 6'd20, 1'b1);
    wait_req();
    exp_r = ref_result(3'd5, 32'd1000, 32'd3);
    for (int i = 0; i < 10; i++) begin
      i_issue_valid = (i == 3);
      i_rs1_data    = 32'd77;
      i_rs2_data    = 32'd0;
      i_tag         = 6'd33;
      chk("hold_req", 32'(o_cdb_req), 32'd1);
      chk("hold_busy", 32'(o_busy), 32'd1);
      chk("hold_tag", 32'(o_cdb_tag), 32'd20);
      chk("hold_result", o_cdb_result, exp_r);
      tick();
    end
    i_issue_valid = 1'b0;
    i_cdb_grant   = 1'b1;
    tick();
    chk("busy_after_late_grant", 32'(o_busy), 32'd0);

    // Flush mid-CALC
    issue(3'd4, 32'd12345, 32'd17, 6'd21, 1'b0);
    repeat (15) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("flush_calc_busy", 32'(o_busy), 32'd0);
    chk("flush_calc_req", 32'(o_cdb_req), 32'd0);

    // Flush in DONE with grant in the same cycle: nothing broadcast
    i_cdb_grant = 1'b0;
    issue(3'd7, 32'd999, 32'd10, 6'd22, 1'b0);
    wait_req();
    i_flush     = 1'b1;
    i_cdb_grant = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("flush_done_busy", 32'(o_busy), 32'd0);
    chk("flush_done_req", 32'(o_cdb_req), 32'd0);
    run_op(3'd6, 32'hFFFF_FF9C, 32'd7, 6'd23);

    // Synchronous reset mid-CALC
    issue(3'd5, 32'hDEAD_BEEF, 32'd3, 6'd42, 1'b0);
    repeat (10) tick();
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_req", 32'(o_cdb_req), 32'd0);
    chk("midrst_tag", 32'(o_cdb_tag), 32'd0);
    chk("midrst_result", o_cdb_result, 32'd0);
    run_op(3'd4, 32'd50, 32'hFFFF_FFF9, 6'd24);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom();
      b  = $urandom();
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
        3:       b = $urandom_range(1, 50);
        4:       b = b | 32'h8000_0000;
        default: ;
      endcase
      run_op(f3, a, b, 6'($urandom_range(0, 63)));
    end

    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_exec_unit.md
# div_exec_unit

Iterative 32-bit integer divide execution unit for the out-of-order core. It sits directly downstream of the issue unit's divide issue port and consumes one issued RV32M DIV/DIVU/REM/REMU operation at a time. It computes the result with a radix-2 restoring algorithm and holds it on a CDB request until the CDB arbiter grants it. It asserts busy for the whole operation so the issue unit stops issuing to the divide queue.

## Interface
- DATA_W, 32, operand/result width (the algorithm is defined for 32 only)
- TAG_W, 6, ROB/physical tag width carried to the CDB
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_issue_valid  in  1  issue unit presents a divide op this cycle
- i_rs1_data  in  DATA_W  dividend
- i_rs2_data  in  DATA_W  divisor
- i_funct3  in  3  4=DIV, 5=DIVU, 6=REM, 7=REMU; other values are treated as DIVU
- i_tag  in  TAG_W  destination tag
- i_flush  in  1  branch mispredict flush; kills any in-flight op
- i_cdb_grant  in  1  CDB arbiter accepts this unit's result this cycle
- o_busy  out  1  unit not in IDLE; issue unit must not issue
- o_cdb_req  out  1  result valid, requesting CDB
- o_cdb_tag  out  TAG_W  tag of the held result
- o_cdb_result  out  DATA_W  quotient or remainder

## Operation
- States: IDLE, CALC, FIX, DONE. o_busy = (state != IDLE). o_cdb_req = (state == DONE).
- IDLE, issue accepted (i_issue_valid and not i_flush):
  - Latch i_tag, the op type and operand signs.
  - Signed ops (DIV/REM) load |rs1| and |rs2|. Unsigned ops load the raw operands.
  - Clear remainder register and iteration counter (6 bits), then go to CALC.
- Special cases are decided at acceptance and go directly to DONE with the result loaded:
  - Divisor 0: DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = rs1.
  - Signed overflow (DIV/REM with rs1 = 0x80000000, rs2 = 0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- CALC, one iteration per cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from rem using a 33-bit subtract.
  - If the result is non-negative, commit it and set quo[0] = 1.
  - Increment the counter. After 32 iterations (counter == 31 at the edge) go to FIX.
- FIX: apply signs for signed ops.
  - Quotient is negated if sign(rs1) XOR sign(rs2).
  - Remainder takes the sign of rs1 (negated if rs1 was negative).
  - Select quotient (funct3 4/5) or remainder (6/7) into the result register, then go to DONE.
- DONE: hold tag and result stable until i_cdb_grant is sampled high, then go to IDLE. A new issue is not accepted on the grant edge.
- i_flush (highest priority, any state): go to IDLE at the next edge. o_cdb_req drops, and no result is broadcast even if the grant is high in the same cycle. An issue presented in the flush cycle is dropped.
- i_issue_valid while o_busy is high is a protocol violation and is ignored (no state change).
- Reset: state = IDLE. o_busy = 0, o_cdb_req = 0, o_cdb_tag = 0, o_cdb_result = 0, counter = 0.

## Timing
- Acceptance edge E0. Normal op: CALC on cycles after E0 through E32, FIX after E32, DONE (o_cdb_req = 1) after E33.
- Normal-op latency: issue to o_cdb_req is 34 cycles. Special cases: o_cdb_req = 1 one cycle after E0.
- o_busy rises the cycle after E0 and falls the cycle after the grant edge. The earliest next acceptance is the cycle after the grant.
- Outputs are registered only; there are no combinational paths from inputs to outputs.
- Reset asserted mid-operation forces IDLE at the next edge, identical to flush.

## Test plan
- DIVU 100/7, tag 5, grant held high: o_cdb_req rises exactly 34 cycles after issue with result 14, tag 5; o_busy low the cycle after the grant.
- DIV −7/2 → −3 (0xFFFFFFFD). REM −7/2 → −1. REMU 0xFFFFFFF9/2 → 1. Each takes 34 cycles.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5. DIV 0x80000000/−1 → 0x80000000 and REM → 0. Each with o_cdb_req one cycle after issue.
- Grant withheld for 10 cycles in DONE: result and tag stay stable, o_busy stays high, and a second i_issue_valid during this window is ignored.
- i_flush at iteration 15, then at DONE with the grant high in the same cycle: no broadcast, IDLE next cycle, and a fresh issue next cycle completes correctly.
- Reset (i_rst_n = 0 for 1 cycle) mid-CALC: all outputs 0 on the next cycle, and a subsequent op completes normally.
